// File: rtl/episode_buffer.sv
// Episode buffer: collects one token per gamma slot into a fill bank and, on each
// theta boundary, publishes the completed episode through a valid/ready output bank.
module episode_buffer #(
   parameter int         TOKEN_W   = 8,
   parameter logic [2:0] LAST_SLOT = 3'd7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           gamma_cnt,
   input  logic                 theta_tick,
   input  logic                 tok_valid,
   input  logic [TOKEN_W-1:0]   tok_data,
   output logic                 ep_valid,
   input  logic                 ep_ready,
   output logic [8*TOKEN_W-1:0] ep_data,
   output logic [7:0]           ep_mask,
   output logic [7:0]           ep_seq,
   output logic [7:0]           coll_cnt,
   output logic [7:0]           drop_cnt,
   output logic                 ep_overflow
);

   logic [8*TOKEN_W-1:0] fill_data_q, fill_data_d;
   logic [7:0]           fill_mask_q, fill_mask_d;
   logic [8*TOKEN_W-1:0] out_data_q,  out_data_d;
   logic [7:0]           out_mask_q,  out_mask_d;
   logic                 out_valid_q, out_valid_d;
   logic [7:0]           out_seq_q,   out_seq_d;
   logic [7:0]           ep_cnt_q,    ep_cnt_d;
   logic [7:0]           coll_q,      coll_d;
   logic [7:0]           drop_q,      drop_d;
   logic                 ovf_q,       ovf_d;

   logic out_free, close, publish, lose, slot_ok, tok_keep, tok_coll;

   assign out_free = !out_valid_q || ep_ready;
   assign close    = theta_tick && (|fill_mask_q);
   assign publish  = close && out_free;
   assign lose     = close && !out_free;
   assign slot_ok  = (gamma_cnt <= LAST_SLOT);
   // A token on the boundary clock lands in the freshly cleared bank, so it can never collide.
   assign tok_keep = tok_valid && slot_ok && (theta_tick || !fill_mask_q[gamma_cnt]);
   assign tok_coll = tok_valid && !tok_keep;

   // NOTE: every variable gets a default first, so no path through this block can infer a latch.
   always_comb begin
      fill_data_d = fill_data_q;
      fill_mask_d = fill_mask_q;
      out_data_d  = out_data_q;
      out_mask_d  = out_mask_q;
      out_valid_d = out_valid_q;
      out_seq_d   = out_seq_q;
      ep_cnt_d    = ep_cnt_q;
      coll_d      = coll_q;
      drop_d      = drop_q;
      ovf_d       = 1'b0;

      if (out_valid_q && ep_ready) out_valid_d = 1'b0;

      if (publish) begin
         out_data_d  = fill_data_q;
         out_mask_d  = fill_mask_q;
         out_valid_d = 1'b1;
         out_seq_d   = ep_cnt_q;
         ep_cnt_d    = ep_cnt_q + 8'd1;
      end

      if (lose) begin
         ovf_d = 1'b1;
         if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end

      // Clearing data with the mask keeps empty slots reading as zero once published.
      if (theta_tick) begin
         fill_mask_d = '0;
         fill_data_d = '0;
      end

      if (tok_keep) begin
         fill_data_d[int'(gamma_cnt)*TOKEN_W +: TOKEN_W] = tok_data;
         fill_mask_d[gamma_cnt] = 1'b1;
      end

      if (tok_coll && coll_q != 8'hFF) coll_d = coll_q + 8'd1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values computed above regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the data banks are reset too, because a reset must erase pending tokens
         // and the published payload, not just invalidate them.
         fill_data_q <= '0;
         fill_mask_q <= '0;
         out_data_q  <= '0;
         out_mask_q  <= '0;
         out_valid_q <= 1'b0;
         out_seq_q   <= '0;
         ep_cnt_q    <= '0;
         coll_q      <= '0;
         drop_q      <= '0;
         ovf_q       <= 1'b0;
      end else begin
         fill_data_q <= fill_data_d;
         fill_mask_q <= fill_mask_d;
         out_data_q  <= out_data_d;
         out_mask_q  <= out_mask_d;
         out_valid_q <= out_valid_d;
         out_seq_q   <= out_seq_d;
         ep_cnt_q    <= ep_cnt_d;
         coll_q      <= coll_d;
         drop_q      <= drop_d;
         ovf_q       <= ovf_d;
      end
   end

   assign ep_valid    = out_valid_q;
   assign ep_data     = out_data_q;
   assign ep_mask     = out_mask_q;
   assign ep_seq      = out_seq_q;
   assign coll_cnt    = coll_q;
   assign drop_cnt    = drop_q;
   assign ep_overflow = ovf_q;

endmodule

// File: tb/tb_episode_buffer.sv
// Directed bench for episode_buffer: stimulus pushes hand-computed episodes into a
// scoreboard queue; a negedge monitor compares every presented episode against it.
module tb_episode_buffer;

   localparam int TOKEN_W = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [2:0]           gamma_cnt;
   logic                 theta_tick;
   logic                 tok_valid;
   logic [TOKEN_W-1:0]   tok_data;
   logic                 ep_valid;
   logic                 ep_ready;
   logic [8*TOKEN_W-1:0] ep_data;
   logic [7:0]           ep_mask;
   logic [7:0]           ep_seq;
   logic [7:0]           coll_cnt;
   logic [7:0]           drop_cnt;
   logic                 ep_overflow;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  mask;
      logic [7:0]  seq;
   } ep_t;

   ep_t sb[$];
   int  n_vec = 0;
   int  n_err = 0;

   episode_buffer #(.TOKEN_W(TOKEN_W), .LAST_SLOT(3'd7)) dut (
      .clk        (clk),
      .rst        (rst),
      .gamma_cnt  (gamma_cnt),
      .theta_tick (theta_tick),
      .tok_valid  (tok_valid),
      .tok_data   (tok_data),
      .ep_valid   (ep_valid),
      .ep_ready   (ep_ready),
      .ep_data    (ep_data),
      .ep_mask    (ep_mask),
      .ep_seq     (ep_seq),
      .coll_cnt   (coll_cnt),
      .drop_cnt   (drop_cnt),
      .ep_overflow(ep_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Applies one clock of inputs, returns #1 after the edge that sampled them.
   task automatic step(input logic tv, input logic [7:0] td, input logic [2:0] g,
                       input logic th, input logic rdy);
      tok_valid  = tv;
      tok_data   = td;
      gamma_cnt  = g;
      theta_tick = th;
      ep_ready   = rdy;
      @(posedge clk);
      #1;
   endtask

   function automatic ep_t mk(input logic [63:0] d, input logic [7:0] m, input logic [7:0] s);
      ep_t e;
      e.data = d;
      e.mask = m;
      e.seq  = s;
      return e;
   endfunction

   // Monitor: every clock an episode is presented it must match the scoreboard head;
   // the head retires only when the consumer accepts it.
   always @(negedge clk) begin
      if (!rst && ep_valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_episode: got seq %0d mask %h expected none (t=%0t)",
                     ep_seq, ep_mask, $time);
         end else begin
            check("ep_data", ep_data, sb[0].data);
            check("ep_mask", {56'd0, ep_mask}, {56'd0, sb[0].mask});
            check("ep_seq",  {56'd0, ep_seq},  {56'd0, sb[0].seq});
            if (ep_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      step(1'b1, 8'hEE, 3'd0, 1'b1, 1'b1);
      rst = 1'b0;

      check("rst_ep_valid",  {63'd0, ep_valid},    64'd0);
      check("rst_ep_data",   ep_data,              64'd0);
      check("rst_ep_mask",   {56'd0, ep_mask},     64'd0);
      check("rst_ep_seq",    {56'd0, ep_seq},      64'd0);
      check("rst_coll_cnt",  {56'd0, coll_cnt},    64'd0);
      check("rst_drop_cnt",  {56'd0, drop_cnt},    64'd0);
      check("rst_overflow",  {63'd0, ep_overflow}, 64'd0);

      // Full episode: slot k = k+1, seq 0.
      for (int k = 0; k < 8; k++) step(1'b1, 8'(k + 1), 3'(k), 1'b0, 1'b1);
      sb.push_back(mk(64'h0807_0605_0403_0201, 8'hFF, 8'd0));
      step(1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
      check("full_ep_valid", {63'd0, ep_valid}, 64'd1);
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      check("full_accepted", {63'd0, ep_valid}, 64'd0);

      // Collisions in one gamma slot: only the first token survives.
      step(1'b1, 8'h11, 3'd2, 1'b0, 1'b1);
      step(1'b1, 8'h22, 3'd2, 1'b0, 1'b1);
      step(1'b1, 8'h33, 3'd2, 1'b0, 1'b1);
      check("coll_cnt_2", {56'd0, coll_cnt}, 64'd2);
      sb.push_back(mk(64'h0000_0000_0011_0000, 8'h04, 8'd1));
      step(1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);

      // Stalled consumer across two boundaries: second episode is lost.
      step(1'b1, 8'hA1, 3'd0, 1'b0, 1'b0);
      sb.push_back(mk(64'h0000_0000_0000_00A1, 8'h01, 8'd2));
      step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
      step(1'b1, 8'hB2, 3'd1, 1'b0, 1'b0);
      check("no_ovf_yet", {63'd0, ep_overflow}, 64'd0);
      step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
      check("ovf_pulse",  {63'd0, ep_overflow}, 64'd1);
      check("drop_cnt_1", {56'd0, drop_cnt},    64'd1);
      check("held_seq",   {56'd0, ep_seq},      64'd2);
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      check("ovf_one_clk", {63'd0, ep_overflow}, 64'd0);
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      check("stall_accepted", {63'd0, ep_valid}, 64'd0);

      // Back-to-back accept and publish; token on the boundary goes to slot 0.
      step(1'b1, 8'h5C, 3'd3, 1'b0, 1'b1);
      sb.push_back(mk(64'h0000_0000_5C00_0000, 8'h08, 8'd3));
      step(1'b1, 8'h77, 3'd0, 1'b1, 1'b1);
      sb.push_back(mk(64'h0000_0000_0000_0077, 8'h01, 8'd4));
      step(1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
      check("b2b_valid",  {63'd0, ep_valid},    64'd1);
      check("b2b_no_ovf", {63'd0, ep_overflow}, 64'd0);
      check("b2b_seq",    {56'd0, ep_seq},      64'd4);
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);

      // Empty episode publishes nothing and keeps the sequence counter.
      step(1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
      check("empty_no_valid", {63'd0, ep_valid},    64'd0);
      check("empty_no_ovf",   {63'd0, ep_overflow}, 64'd0);
      step(1'b1, 8'h99, 3'd5, 1'b0, 1'b1);
      sb.push_back(mk(64'h0000_9900_0000_0000, 8'h20, 8'd5));
      step(1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);

      // 300 collisions saturate coll_cnt.
      step(1'b1, 8'h01, 3'd6, 1'b0, 1'b1);
      for (int i = 0; i < 300; i++) step(1'b1, 8'(i), 3'd6, 1'b0, 1'b1);
      check("coll_sat", {56'd0, coll_cnt}, 64'd255);

      // Present an episode, stall it, then reset mid-handshake and mid-episode.
      sb.push_back(mk(64'h0001_0000_0000_0000, 8'h40, 8'd6));
      step(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
      step(1'b1, 8'h42, 3'd1, 1'b0, 1'b0);
      rst = 1'b1;
      step(1'b1, 8'h55, 3'd2, 1'b1, 1'b1);
      rst = 1'b0;
      sb.delete();
      check("rst2_ep_valid", {63'd0, ep_valid},    64'd0);
      check("rst2_ep_data",  ep_data,              64'd0);
      check("rst2_ep_mask",  {56'd0, ep_mask},     64'd0);
      check("rst2_ep_seq",   {56'd0, ep_seq},      64'd0);
      check("rst2_coll_cnt", {56'd0, coll_cnt},    64'd0);
      check("rst2_drop_cnt", {56'd0, drop_cnt},    64'd0);
      check("rst2_overflow", {63'd0, ep_overflow}, 64'd0);

      // Fill bank was discarded: a boundary right after reset publishes nothing.
      step(1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
      check("post_rst_empty", {63'd0, ep_valid},    64'd0);
      check("post_rst_noovf", {63'd0, ep_overflow}, 64'd0);
      step(1'b1, 8'h3D, 3'd7, 1'b0, 1'b1);
      sb.push_back(mk(64'h3D00_0000_0000_0000, 8'h80, 8'd0));
      step(1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/episode_buffer.md
EPISODE_BUFFER -- requirements
Module: episode_buffer

Interface
REQ-001 The block SHALL have parameter TOKEN_W, default 8, giving the width of one gamma-cycle token (phase code / neuron ID).
REQ-002 The block SHALL have parameter LAST_SLOT, default 3'd7, giving the highest gamma index in an episode; slots 0..LAST_SLOT exist and the rest are unused.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 gamma_cnt  input  3  gamma position within the current episode, from the theta stage.
REQ-006 theta_tick  input  1  one-clock episode-boundary pulse, from the theta stage.
REQ-007 tok_valid  input  1  a token is offered this clock.
REQ-008 tok_data  input  TOKEN_W  token payload.
REQ-009 ep_valid  output  1  a completed episode is presented.
REQ-010 ep_ready  input  1  the consumer accepts the presented episode.
REQ-011 ep_data  output  8*TOKEN_W  episode payload; slot k occupies bits [k*TOKEN_W +: TOKEN_W].
REQ-012 ep_mask  output  8  bit k is set when slot k of the presented episode holds a token.
REQ-013 ep_seq  output  8  sequence number of the presented episode.
REQ-014 coll_cnt  output  8  saturating count of tokens dropped because their slot was already full.
REQ-015 drop_cnt  output  8  saturating count of whole episodes lost because the output was busy.
REQ-016 ep_overflow  output  1  one-clock pulse each time an episode is lost.

Function
REQ-017 Storage SHALL be two banks: a fill bank (data plus fill_mask) and an output bank (ep_data plus ep_mask).
REQ-018 On tok_valid with theta_tick=0, gamma_cnt<=LAST_SLOT and fill_mask[gamma_cnt]=0, the block SHALL write tok_data to fill slot gamma_cnt and set fill_mask[gamma_cnt] in the same clock.
REQ-019 On tok_valid with fill_mask[gamma_cnt]=1, the block SHALL discard the token, leave the slot unchanged and increment coll_cnt, saturating at 255; only the first token per gamma cycle is kept.
REQ-020 On tok_valid with gamma_cnt>LAST_SLOT, the block SHALL discard the token and increment coll_cnt.
REQ-021 The output is "free" when ep_valid=0 or (ep_valid && ep_ready) in the same clock.
REQ-022 Episode close on theta_tick=1 with fill_mask!=0 and output free: the fill bank SHALL copy to the output bank on the next edge, ep_valid SHALL become 1, and ep_seq SHALL become the current episode counter, which then increments mod 256.
REQ-023 Episode close on theta_tick=1 with fill_mask!=0 and output not free: the fill bank SHALL be discarded, ep_overflow SHALL pulse for 1 clock, drop_cnt SHALL increment (saturating), and the output bank SHALL remain unchanged.
REQ-024 Episode close on theta_tick=1 with fill_mask==0: the block SHALL publish nothing, pulse nothing and leave the episode counter unchanged.
REQ-025 On every theta_tick, fill_mask SHALL clear; a tok_valid in that same clock belongs to the new episode and SHALL be written to slot gamma_cnt (normally 0) of the cleared bank.
REQ-026 Handshake: on ep_valid && ep_ready with no concurrent publish, ep_valid SHALL drop the next clock; ep_data, ep_mask and ep_seq SHALL hold stable while ep_valid=1 and ep_ready=0.
REQ-027 Latency: an episode SHALL be visible on ep_valid one clock after its theta_tick; the block SHALL never introduce a bubble on a back-to-back accept-and-publish.
REQ-028 Slot data in ep_data whose ep_mask bit is 0 SHALL read as zero.

Reset
REQ-029 While rst=1, the block SHALL force ep_valid, ep_overflow, ep_mask, ep_data, ep_seq, coll_cnt, drop_cnt, fill_mask, fill data and the episode counter to 0; all inputs are ignored.
REQ-030 A reset asserted mid-episode or mid-handshake SHALL discard all pending data without any ep_overflow pulse.

Verification
REQ-031 A bench SHALL cover: one token per gamma cnt=0..7, tok_data=k+1, then theta_tick with ep_ready=1 -> next clock ep_valid=1, ep_mask=8'hFF, slot k=k+1, ep_seq=0.
REQ-032 A bench SHALL cover: three tokens 0x11, 0x22, 0x33 while gamma_cnt=2 -> slot 2=0x11, coll_cnt=2, ep_mask=8'h04 at close.
REQ-033 A bench SHALL cover: ep_ready=0 held across two theta_ticks with non-empty fills -> first episode held stable, ep_overflow pulses once, drop_cnt=1, ep_seq stays 0.
REQ-034 A bench SHALL cover: theta_tick with ep_valid=1 and ep_ready=1 in the same clock -> no overflow, new episode presented next clock, ep_seq=1, ep_valid stays 1.
REQ-035 A bench SHALL cover: theta_tick with no tokens in the episode -> ep_valid stays 0, episode counter unchanged; and tok_valid coincident with theta_tick (gamma_cnt=0) -> token appears in slot 0 of the next episode.
REQ-036 A bench SHALL cover: 300 collisions -> coll_cnt=255 (saturated); rst pulse mid-episode -> all outputs 0 the following clock.
